// File: rtl/paddle_motion_ctrl.sv
// ---------------------------------------------------------------------------
// paddle_motion_ctrl
//
// Per-frame game-state controller for the two-player paddle display. Once per
// frame, at the start of vertical blanking, the eight player switches are
// snapshotted. The controller then walks a fixed move/clamp/collision sequence
// (P1 x, P1 y, P2 x, P2 y) on working copies of the paddle positions and loads
// all four outputs together in a single commit cycle. Because of this, the
// pixel generator only ever sees positions change during blanking.
//
// Ports
//   clk                         system clock (50 MHz)
//   clear                       asynchronous active-low reset
//   hCount, vCount              scan position from the VGA controller
//   up, down, left, right       player 1 switches (asynchronous, active-high)
//   up2, down2, left2, right2   player 2 switches (asynchronous, active-high)
//   p1_x, p1_y, p2_x, p2_y      committed top-left corners of both paddles
//   busy                        high while an update sequence is running
//   frame_tick                  one-cycle pulse at the start of vertical blanking
// ---------------------------------------------------------------------------
module paddle_motion_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int PAD_W     = 16,
    parameter int PAD_H     = 64,
    parameter int STEP      = 4,
    parameter int FRAME_DIV = 1,
    parameter int P1_X0     = 32,
    parameter int P1_Y0     = 208,
    parameter int P2_X0     = 592,
    parameter int P2_Y0     = 208
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       up2,
    input  logic       down2,
    input  logic       left2,
    input  logic       right2,
    output logic [9:0] p1_x,
    output logic [9:0] p1_y,
    output logic [9:0] p2_x,
    output logic [9:0] p2_y,
    output logic       busy,
    output logic       frame_tick
);

    // 11-bit limits so that pos+STEP cannot wrap before it is clamped
    localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - PAD_W);
    localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - PAD_H);
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [10:0] PW       = 11'(PAD_W);
    localparam logic [10:0] PH       = 11'(PAD_H);
    localparam logic [3:0]  DIV_LAST = 4'(FRAME_DIV - 1);

    // Bit positions inside the switch vectors
    localparam int UP1 = 7, DN1 = 6, LF1 = 5, RT1 = 4;
    localparam int UP2 = 3, DN2 = 2, LF2 = 1, RT2 = 0;

    typedef enum logic [2:0] {IDLE, P1_X, P1_Y, P2_X, P2_Y, COMMIT} state_t;

    // One-axis step with saturation at 0 and at lim. Opposing or absent
    // switches leave the position alone.
    function automatic logic [9:0] step_axis(input logic [9:0]  pos,
                                             input logic        dec,
                                             input logic        inc,
                                             input logic [10:0] lim);
        logic [10:0] wide;
        wide = {1'b0, pos};
        if (dec && !inc) begin
            wide = (wide < STEP_W) ? 11'd0 : wide - STEP_W;
        end else if (inc && !dec) begin
            wide = wide + STEP_W;
            if (wide > lim) wide = lim;
        end
        return 10'(wide);
    endfunction

    // Strict rectangle overlap: touching edges are not a collision.
    function automatic logic overlap(input logic [9:0] ax, input logic [9:0] ay,
                                     input logic [9:0] bx, input logic [9:0] by);
        return ({1'b0, ax} < {1'b0, bx} + PW) && ({1'b0, bx} < {1'b0, ax} + PW) &&
               ({1'b0, ay} < {1'b0, by} + PH) && ({1'b0, by} < {1'b0, ay} + PH);
    endfunction

    state_t      state;
    logic [7:0]  sw_p0, sw_p1;     // two-flop synchroniser
    logic [7:0]  sw_snap;          // switches frozen for the running sequence
    logic        tick_cond, tick_cond_q;
    logic [3:0]  div_cnt;
    logic        start_update;
    logic [9:0]  w1x, w1y, w2x, w2y;
    logic [9:0]  cand;
    logic        cand_hit;

    assign tick_cond    = (hCount == 10'd0) && (vCount == 10'(V_ACTIVE));
    assign start_update = frame_tick && (state == IDLE) && (div_cnt == DIV_LAST);

    // Candidate for the axis handled in the current state, tested against the
    // other paddle's working rectangle (P2 therefore sees P1's new position).
    always_comb begin
        cand     = '0;
        cand_hit = 1'b1;
        case (state)
            P1_X: begin
                cand     = step_axis(w1x, sw_snap[LF1], sw_snap[RT1], X_MAX);
                cand_hit = overlap(cand, w1y, w2x, w2y);
            end
            P1_Y: begin
                cand     = step_axis(w1y, sw_snap[UP1], sw_snap[DN1], Y_MAX);
                cand_hit = overlap(w1x, cand, w2x, w2y);
            end
            P2_X: begin
                cand     = step_axis(w2x, sw_snap[LF2], sw_snap[RT2], X_MAX);
                cand_hit = overlap(cand, w2y, w1x, w1y);
            end
            P2_Y: begin
                cand     = step_axis(w2y, sw_snap[UP2], sw_snap[DN2], Y_MAX);
                cand_hit = overlap(w2x, cand, w1x, w1y);
            end
            default: ;
        endcase
    end

    // Control: synchroniser, tick edge detect, divider, sequencer, commit
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sw_p0       <= '0;
            sw_p1       <= '0;
            tick_cond_q <= 1'b0;
            frame_tick  <= 1'b0;
            div_cnt     <= '0;
            state       <= IDLE;
            busy        <= 1'b0;
            p1_x        <= 10'(P1_X0);
            p1_y        <= 10'(P1_Y0);
            p2_x        <= 10'(P2_X0);
            p2_y        <= 10'(P2_Y0);
        end else begin
            sw_p0       <= {up, down, left, right, up2, down2, left2, right2};
            sw_p1       <= sw_p0;
            tick_cond_q <= tick_cond;
            // counts hold for two clocks, so only the rising edge is a tick
            frame_tick  <= tick_cond && !tick_cond_q;

            // ticks during a running sequence still advance the divider
            if (frame_tick) begin
                div_cnt <= (div_cnt == DIV_LAST) ? 4'd0 : div_cnt + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (start_update) begin
                        state <= P1_X;
                        busy  <= 1'b1;
                    end
                end
                P1_X: state <= P1_Y;
                P1_Y: state <= P2_X;
                P2_X: state <= P2_Y;
                P2_Y: state <= COMMIT;
                COMMIT: begin
                    p1_x  <= w1x;
                    p1_y  <= w1y;
                    p2_x  <= w2x;
                    p2_y  <= w2y;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Working data: loaded from the committed outputs at the start of a
    // sequence; a reset mid-sequence just strands these values, harmlessly.
    always_ff @(posedge clk) begin
        if (start_update) begin
            sw_snap <= sw_p1;
            w1x     <= p1_x;
            w1y     <= p1_y;
            w2x     <= p2_x;
            w2y     <= p2_y;
        end else begin
            case (state)
                P1_X: if (!cand_hit) w1x <= cand;
                P1_Y: if (!cand_hit) w1y <= cand;
                P2_X: if (!cand_hit) w2x <= cand;
                P2_Y: if (!cand_hit) w2y <= cand;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_paddle_motion_ctrl
//
// Two instances (update every frame, update every third frame) share one set
// of inputs. Frames are compressed to a few dozen clocks. Expected positions
// come from a plain-integer model of the movement rules; committed results
// are queued per instance and popped by a monitor whenever busy falls.
// ---------------------------------------------------------------------------
module tb_paddle_motion_ctrl;

    localparam int FLEN  = 24;
    localparam int STEP  = 4;
    localparam int X_MAX = 640 - 16;
    localparam int Y_MAX = 480 - 64;

    localparam logic [7:0] S_UP1 = 8'h80, S_DN1 = 8'h40, S_LF1 = 8'h20, S_RT1 = 8'h10;
    localparam logic [7:0] S_UP2 = 8'h08, S_DN2 = 8'h04, S_LF2 = 8'h02, S_RT2 = 8'h01;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       clear;
    logic [9:0] hCount, vCount;
    logic       up, down, left, right, up2, down2, left2, right2;
    logic [9:0] p1x [2];
    logic [9:0] p1y [2];
    logic [9:0] p2x [2];
    logic [9:0] p2y [2];
    logic       busy [2];
    logic       ft [2];

    paddle_motion_ctrl #(.FRAME_DIV(1)) dut0 (
        .clk(clk), .clear(clear), .hCount(hCount), .vCount(vCount),
        .up(up), .down(down), .left(left), .right(right),
        .up2(up2), .down2(down2), .left2(left2), .right2(right2),
        .p1_x(p1x[0]), .p1_y(p1y[0]), .p2_x(p2x[0]), .p2_y(p2y[0]),
        .busy(busy[0]), .frame_tick(ft[0])
    );

    paddle_motion_ctrl #(.FRAME_DIV(3)) dut1 (
        .clk(clk), .clear(clear), .hCount(hCount), .vCount(vCount),
        .up(up), .down(down), .left(left), .right(right),
        .up2(up2), .down2(down2), .left2(left2), .right2(right2),
        .p1_x(p1x[1]), .p1_y(p1y[1]), .p2_x(p2x[1]), .p2_y(p2y[1]),
        .busy(busy[1]), .frame_tick(ft[1])
    );

    int tests = 0;
    int fails = 0;

    typedef struct { int p1x; int p1y; int p2x; int p2y; } pos_t;
    pos_t model [2];
    int   mdiv [2];
    pos_t q0 [$];
    pos_t q1 [$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int mv(input int pos, input bit neg, input bit fwd, input int maxv);
        if (neg == fwd) return pos;
        if (neg) return (pos < STEP) ? 0 : pos - STEP;
        return (pos + STEP > maxv) ? maxv : pos + STEP;
    endfunction

    function automatic bit ov(input int ax, input int ay, input int bx, input int by);
        return (ax < bx + 16) && (bx < ax + 16) && (ay < by + 64) && (by < ay + 64);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            model[i] = '{32, 208, 592, 208};
            mdiv[i]  = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_update(input int i);
        pos_t p;
        int   c;
        p = model[i];
        c = mv(p.p1x, left, right, X_MAX);
        if (!ov(c, p.p1y, p.p2x, p.p2y)) p.p1x = c;
        c = mv(p.p1y, up, down, Y_MAX);
        if (!ov(p.p1x, c, p.p2x, p.p2y)) p.p1y = c;
        c = mv(p.p2x, left2, right2, X_MAX);
        if (!ov(c, p.p2y, p.p1x, p.p1y)) p.p2x = c;
        c = mv(p.p2y, up2, down2, Y_MAX);
        if (!ov(p.p2x, c, p.p1x, p.p1y)) p.p2y = c;
        model[i] = p;
        if (i == 0) q0.push_back(p);
        else        q1.push_back(p);
    endtask

    task automatic model_tick(input int i, input bit blocked, output bit accepted);
        accepted = 1'b0;
        if (mdiv[i] == div_of(i) - 1) begin
            mdiv[i] = 0;
            if (!blocked) begin
                accepted = 1'b1;
                model_update(i);
            end
        end else begin
            mdiv[i] = mdiv[i] + 1;
        end
    endtask

    // Scan counts that never form the blanking-start condition, including
    // near misses on either coordinate.
    task automatic drive_quiet();
        case ($urandom % 3)
            0: begin hCount = 10'($urandom_range(1, 799)); vCount = 10'd480; end
            1: begin hCount = 10'd0; vCount = 10'($urandom_range(0, 479)); end
            default: begin hCount = 10'($urandom_range(1, 799)); vCount = 10'($urandom_range(0, 524)); end
        endcase
    endtask

    task automatic check_pos(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_p1x_u%0d", tag, i), int'(p1x[i]), model[i].p1x);
            check($sformatf("%s_p1y_u%0d", tag, i), int'(p1y[i]), model[i].p1y);
            check($sformatf("%s_p2x_u%0d", tag, i), int'(p2x[i]), model[i].p2x);
            check($sformatf("%s_p2y_u%0d", tag, i), int'(p2y[i]), model[i].p2y);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_p1x_u%0d", tag, i), int'(p1x[i]), 32);
            check($sformatf("%s_p1y_u%0d", tag, i), int'(p1y[i]), 208);
            check($sformatf("%s_p2x_u%0d", tag, i), int'(p2x[i]), 592);
            check($sformatf("%s_p2y_u%0d", tag, i), int'(p2y[i]), 208);
            check($sformatf("%s_busy_u%0d", tag, i), int'(busy[i]), 0);
            check($sformatf("%s_tick_u%0d", tag, i), int'(ft[i]), 0);
        end
    endtask

    // Switches change well away from any tick so the synchronisers settle.
    task automatic set_switches(input logic [7:0] pat);
        {up, down, left, right, up2, down2, left2, right2} = pat;
        repeat (4) begin
            @(negedge clk);
            drive_quiet();
        end
    endtask

    // One compressed frame. dbl adds a second tick 3 clocks after the first
    // (lands while busy). abort_req pulls clear low during the P2 x step.
    task automatic run_frame(input bit dbl, input bit abort_req);
        int nft [2];
        bit acc0 [2];
        bit acc;
        int seen;
        int low_cnt;
        bit aborted;
        nft[0] = 0; nft[1] = 0;
        acc0[0] = 1'b0; acc0[1] = 1'b0;
        seen = -1; low_cnt = 0; aborted = 1'b0;
        for (int j = 0; j < FLEN; j++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) if (ft[i]) nft[i]++;
            if (abort_req) begin
                if (!aborted) begin
                    if (seen >= 0) seen++;
                    else if (ft[0]) seen = 0;
                    if (seen == 3) begin
                        clear = 1'b0;
                        model_reset();
                        aborted = 1'b1;
                    end
                end else if (!clear) begin
                    low_cnt++;
                    if (low_cnt == 2) begin
                        check_reset_vals("abort");
                        clear = 1'b1;
                    end
                end
            end
            if (j == 0) begin
                for (int i = 0; i < 2; i++) begin
                    model_tick(i, 1'b0, acc);
                    acc0[i] = acc;
                end
            end
            if (dbl && j == 3) begin
                for (int i = 0; i < 2; i++) model_tick(i, acc0[i], acc);
            end
            if (j < 2 || (dbl && (j == 3 || j == 4))) begin
                hCount = 10'd0;
                vCount = 10'd480;
            end else begin
                drive_quiet();
            end
        end
        if (!clear) clear = 1'b1;
        for (int i = 0; i < 2; i++)
            check($sformatf("ticks_per_frame_u%0d", i), nft[i], dbl ? 2 : 1);
        check_pos("frame");
    endtask

    task automatic do_frames(input int n, input logic [7:0] pat);
        set_switches(pat);
        repeat (n) run_frame(1'b0, 1'b0);
    endtask

    // Monitor: a falling busy marks a commit; check sequence length, latency
    // from the accepted tick, and the committed coordinates.
    bit prevb [2];
    int since [2];
    int bcnt [2];

    initial begin
        pos_t e;
        bit   have;
        for (int i = 0; i < 2; i++) begin
            prevb[i] = 1'b0; since[i] = -1; bcnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!clear) begin
                    prevb[i] = 1'b0; since[i] = -1; bcnt[i] = 0;
                end else begin
                    if (ft[i] && !busy[i]) since[i] = 0;
                    else if (since[i] >= 0) since[i]++;
                    if (busy[i]) bcnt[i]++;
                    if (prevb[i] && !busy[i]) begin
                        check($sformatf("busy_len_u%0d", i), bcnt[i], 5);
                        check($sformatf("commit_latency_u%0d", i), since[i], 6);
                        have = 1'b0;
                        if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                        if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                        if (have) begin
                            check($sformatf("commit_p1x_u%0d", i), int'(p1x[i]), e.p1x);
                            check($sformatf("commit_p1y_u%0d", i), int'(p1y[i]), e.p1y);
                            check($sformatf("commit_p2x_u%0d", i), int'(p2x[i]), e.p2x);
                            check($sformatf("commit_p2y_u%0d", i), int'(p2y[i]), e.p2y);
                        end else begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_commit_u%0d: got a commit, expected none", i);
                        end
                        bcnt[i] = 0;
                    end
                    prevb[i] = busy[i];
                end
            end
        end
    end

    initial begin
        logic [7:0] pat;
        int         n;
        clear  = 1'b0;
        hCount = 10'd100;
        vCount = 10'd200;
        {up, down, left, right, up2, down2, left2, right2} = 8'h00;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        clear = 1'b1;

        do_frames(3, 8'h00);
        do_frames(1, S_RT1);
        check("single_move_p1x", int'(p1x[0]), 36);
        check("single_move_p1y", int'(p1y[0]), 208);
        do_frames(60, S_UP1);
        check("clamp_low_p1y", int'(p1y[0]), 0);
        do_frames(10, S_RT2);
        check("clamp_high_p2x", int'(p2x[0]), 624);
        do_frames(3, S_LF2 | S_RT2 | S_UP2);
        check("opposite_p2x", int'(p2x[0]), 624);
        check("opposite_p2y", int'(p2y[0]), 196);
        do_frames(60, S_UP2);
        do_frames(80, S_RT1 | S_LF2);

        set_switches(S_RT1 | S_DN1 | S_LF2);
        repeat (4) run_frame(1'b1, 1'b0);
        set_switches(S_LF1 | S_DN2 | S_RT2);
        run_frame(1'b0, 1'b1);

        for (int s = 0; s < 12; s++) begin
            pat = 8'($urandom);
            n   = $urandom_range(3, 20);
            set_switches(pat);
            for (int k = 0; k < n; k++) run_frame(($urandom % 8) == 0, 1'b0);
            if (s == 6) run_frame(1'b0, 1'b1);
        end

        repeat (10) @(negedge clk);
        check("pending_u0", q0.size(), 0);
        check("pending_u1", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/paddle_motion_ctrl.md
Name: paddle_motion_ctrl

Overview:
- Per-frame game-state controller for the two-player paddle display.
- Samples both players' direction switches once per frame at the start of vertical blanking.
- Sequences a fixed move/clamp/collision pipeline and commits new paddle coordinates for the pixel generator.
- Positions change only during blanking, so the active-video scan always sees stable values.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
PAD_W, 16, paddle width in pixels
PAD_H, 64, paddle height in pixels
STEP, 4, pixels moved per axis per update
FRAME_DIV, 1, update every FRAME_DIV frames (1..15)
P1_X0, 32, player 1 reset x
P1_Y0, 208, player 1 reset y
P2_X0, 592, player 2 reset x
P2_Y0, 208, player 2 reset y

Ports:
clk  in  1  50 MHz system clock
clear  in  1  asynchronous, active-low reset
hCount  in  10  horizontal count from VGA controller
vCount  in  10  vertical count from VGA controller
up, down, left, right  in  1 each  player 1 switches, active-high, asynchronous
up2, down2, left2, right2  in  1 each  player 2 switches, active-high, asynchronous
p1_x, p1_y  out  10 each  player 1 top-left corner
p2_x, p2_y  out  10 each  player 2 top-left corner
busy  out  1  update sequence in progress
frame_tick  out  1  one-cycle pulse at start of vertical blanking

Behaviour:
- Reset (clear=0, async):
  - p1/p2 outputs = P1_X0/P1_Y0/P2_X0/P2_Y0.
  - busy=0, frame_tick=0.
  - FSM=IDLE, frame divider=0, synchronisers cleared.
  - Reset asserted mid-sequence aborts the sequence with no partial commit.
- Switch inputs: each passes through a 2-flop synchroniser before use.
- frame_tick:
  - Asserted on the rising edge of the condition (hCount==0 && vCount==V_ACTIVE).
  - Exactly one clk cycle per frame, even though the counts hold for 2 clk cycles.
- Frame divider:
  - Counts frame_ticks 0..FRAME_DIV-1.
  - An update starts on a tick where the count==FRAME_DIV-1; the counter then wraps to 0.
- Snapshot: on an update tick, the 8 synchronised switches are latched. Later switch changes do not affect the running sequence.
- FSM states: IDLE -> P1_X -> P1_Y -> P2_X -> P2_Y -> COMMIT -> IDLE. One state per cycle.
- busy=1 in every non-IDLE state. A frame_tick while busy is ignored, but it still advances the divider.
- Per-axis move:
  - left and right both set, or neither set: no x change. The same rule applies to up/down on y.
  - Negative move: candidate = pos-STEP. If pos<STEP, candidate = 0 (no wrap).
  - Positive move: candidate = pos+STEP, clamped to H_ACTIVE-PAD_W for x and V_ACTIVE-PAD_H for y.
  - Arithmetic is 11-bit internally to detect overflow.
- Collision:
  - Each axis candidate is accepted only if the moving paddle's rectangle would not overlap the other paddle's current working rectangle.
  - Overlap: ax<bx+PAD_W && bx<ax+PAD_W && ay<by+PAD_H && by<ay+PAD_H.
  - A rejected move leaves that axis unchanged. There is no partial step toward contact.
- Evaluation order:
  - P1 x, then P1 y, each against P2's pre-update position.
  - Then P2 x, then P2 y, each against P1's updated working position.
- Commit and latency:
  - In COMMIT all four outputs load simultaneously from the working registers.
  - Tick at cycle 0: busy=1 in cycles 1..5; new outputs visible in cycle 6.
  - Outputs are otherwise held.

Test Plan:
- Reset: clear=0 mid-frame -> p1=(32,208), p2=(592,208), busy=0; release, no switches, 3 frames -> outputs unchanged, one frame_tick per frame.
- Single move: right=1 held across one tick -> p1_x 32->36 visible 6 cycles after frame_tick, busy high exactly 5 cycles, p1_y unchanged.
- Clamp low: P1 at y=2, up=1 -> p1_y=0. Next frame -> stays 0. Clamp high: P2 at x=622, right2=1 -> p2_x=624 (640-16).
- Opposite switches: left2=right2=1 with up2=1 -> p2_x unchanged, p2_y decreases by 4.
- Collision:
  - P1 at (300,200), P2 at (318,200), P1 right=1 -> candidate 304 overlaps (304<334 && 318<320) -> p1_x stays 300.
  - Same frame left2=1 -> P2 candidate 314 overlaps P1 -> p2_x stays 318.
- Divider and reset abort: FRAME_DIV=3 -> updates only on every 3rd frame_tick. Assert clear during P2_X -> outputs return to reset values, no commit, busy=0.
